// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: issues word reads ahead of decode into a DEPTH-entry queue.
// Define FETCH_PERF_CNT_EN to add saturating push and full-stall performance counters.
module fetch_prefetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h80020000,
  parameter int          DEPTH    = 4,
  parameter int          PC_STEP  = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  output logic                   mem_req_out,
  output logic [0:31]            mem_addr_out,
  output logic                   mem_rw_out,
  output logic [0:1]             mem_access_size_out,
  input  logic [0:31]            mem_data_in,
  input  logic                   redirect_in,
  input  logic [0:31]            redirect_pc_in,
  output logic                   dec_valid_out,
  input  logic                   dec_ready_in,
  output logic [0:31]            dec_insn_out,
  output logic [0:31]            dec_pc_out,
`ifdef FETCH_PERF_CNT_EN
  output logic [0:31]            perf_fetch_out,
  output logic [0:31]            perf_stall_out,
`endif
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int              PW        = $clog2(DEPTH);
  localparam int              CW        = PW + 1;
  localparam logic [CW:0]     DEPTH_LIM = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
  localparam logic [0:31]     STEP      = 32'(PC_STEP);

  logic [0:31]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [0:31]   inflight_addr_q, inflight_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [0:31]   insn_q [DEPTH];
  logic [0:31]   pcq_q  [DEPTH];

  logic          issue, push, pop;
  logic [CW:0]   occupancy_sum;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_in[30:31];

  // Requests are throttled so queued plus in-flight words can never exceed DEPTH.
  always_comb begin
    occupancy_sum = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue         = !rst_in && !redirect_in && (occupancy_sum < DEPTH_LIM);
    push          = inflight_q && !redirect_in;
    pop           = dec_valid_out && dec_ready_in;
  end

  always_comb begin
    pc_d            = pc_q;
    inflight_d      = inflight_q;
    inflight_addr_d = inflight_addr_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    if (redirect_in) begin
      pc_d       = {redirect_pc_in[0:29], 2'b00};
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) pc_d = pc_q + STEP;
      inflight_d      = issue;
      inflight_addr_d = pc_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  // Queue storage carries no reset; entries are only visible below count_q.
  always_ff @(posedge clk_in) begin
    if (push && !rst_in) begin
      insn_q[wr_ptr_q] <= mem_data_in;
      pcq_q[wr_ptr_q]  <= inflight_addr_q;
    end
  end

  assign mem_req_out         = issue;
  assign mem_addr_out        = pc_q;
  assign mem_rw_out          = 1'b0;
  assign mem_access_size_out = 2'b11;
  assign dec_valid_out       = !rst_in && (count_q != '0);
  assign dec_insn_out        = insn_q[rd_ptr_q];
  assign dec_pc_out          = pcq_q[rd_ptr_q];
  assign count_out           = rst_in ? '0 : count_q;

`ifdef FETCH_PERF_CNT_EN
  logic [0:31] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + 32'd1;
      if ((count_q == FULL_CNT) && !pop && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_out = perf_fetch_q;
  assign perf_stall_out = perf_stall_q;
`else
  logic unused_full_cnt;
  assign unused_full_cnt = ^FULL_CNT;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: streaming, back-pressure, redirect, wrap and reset.
module tb_fetch_prefetch_queue;

  logic        clk_in;
  logic        rst_in;
  logic        mem_req_out;
  logic [0:31] mem_addr_out;
  logic        mem_rw_out;
  logic [0:1]  mem_access_size_out;
  logic [0:31] mem_data_in;
  logic        redirect_in;
  logic [0:31] redirect_pc_in;
  logic        dec_valid_out;
  logic        dec_ready_in;
  logic [0:31] dec_insn_out;
  logic [0:31] dec_pc_out;
  logic [2:0]  count_out;
`ifdef FETCH_PERF_CNT_EN
  logic [0:31] perf_fetch_out;
  logic [0:31] perf_stall_out;
`endif

  int          totalChecks;
  int          badChecks;
  int          reqSeen;
  int          maxCount;
  logic [31:0] reqAddr;
  logic [0:31] lastAddr;

  fetch_prefetch_queue dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .mem_req_out         (mem_req_out),
    .mem_addr_out        (mem_addr_out),
    .mem_rw_out          (mem_rw_out),
    .mem_access_size_out (mem_access_size_out),
    .mem_data_in         (mem_data_in),
    .redirect_in         (redirect_in),
    .redirect_pc_in      (redirect_pc_in),
    .dec_valid_out       (dec_valid_out),
    .dec_ready_in        (dec_ready_in),
    .dec_insn_out        (dec_insn_out),
    .dec_pc_out          (dec_pc_out),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_out      (perf_fetch_out),
    .perf_stall_out      (perf_stall_out),
`endif
    .count_out           (count_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Memory model: the word at an address is its bitwise inverse, returned one cycle later.
  always @(posedge clk_in) lastAddr <= mem_addr_out;
  assign mem_data_in = ~lastAddr;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic redir,
                               input logic [31:0] target, input logic ready);
    rst_in         = rst;
    redirect_in    = redir;
    redirect_pc_in = target;
    dec_ready_in   = ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("rstReq",   32'(mem_req_out), 32'd0);
    checkOutput("rstValid", 32'(dec_valid_out), 32'd0);
    checkOutput("rstCount", 32'(count_out), 32'd0);
    checkOutput("rwConst",  32'(mem_rw_out), 32'd0);
    checkOutput("sizeConst", 32'(mem_access_size_out), 32'd3);

    // Streaming after reset release with decode always ready
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("a1Req",  32'(mem_req_out), 32'd1);
    checkOutput("a1Addr", mem_addr_out, 32'h80020000);
    tick();
    checkOutput("a2Addr",  mem_addr_out, 32'h80020004);
    checkOutput("a2Valid", 32'(dec_valid_out), 32'd0);
    tick();
    checkOutput("a3Addr",  mem_addr_out, 32'h80020008);
    checkOutput("a3Valid", 32'(dec_valid_out), 32'd1);
    checkOutput("a3Pc",    dec_pc_out, 32'h80020000);
    checkOutput("a3Insn",  dec_insn_out, 32'h7FFDFFFF);
    checkOutput("a3Count", 32'(count_out), 32'd1);
    tick();
    checkOutput("a4Addr",  mem_addr_out, 32'h8002000C);
    checkOutput("a4Pc",    dec_pc_out, 32'h80020004);
    checkOutput("a4Count", 32'(count_out), 32'd1);

    // Reset with a request in flight, then fill with decode stalled
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    reqSeen = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req_out) reqSeen++;
      tick();
    end
    checkOutput("bReqs",  32'(reqSeen), 32'd4);
    checkOutput("bCount", 32'(count_out), 32'd4);
    checkOutput("bReq",   32'(mem_req_out), 32'd0);
    checkOutput("bPc",    dec_pc_out, 32'h80020000);

    // One pop from full admits exactly one refill request
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("cValid", 32'(dec_valid_out), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    reqSeen  = 0;
    maxCount = 0;
    reqAddr  = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req_out) begin
        reqSeen++;
        reqAddr = mem_addr_out;
      end
      if (int'(count_out) > maxCount) maxCount = int'(count_out);
      tick();
    end
    checkOutput("cReqs",  32'(reqSeen), 32'd1);
    checkOutput("cAddr",  reqAddr, 32'h80020010);
    checkOutput("cMax",   32'(maxCount), 32'd4);
    checkOutput("cPc",    dec_pc_out, 32'h80020004);

    // Redirect while a request is in flight
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("dPreReq",  32'(mem_req_out), 32'd1);
    checkOutput("dPreAddr", mem_addr_out, 32'h80020014);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h80020103, 1'b0);
    checkOutput("dRedirReq", 32'(mem_req_out), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("dValid0", 32'(dec_valid_out), 32'd0);
    checkOutput("dCount0", 32'(count_out), 32'd0);
    checkOutput("dReq",    32'(mem_req_out), 32'd1);
    checkOutput("dAddr",   mem_addr_out, 32'h80020100);
    tick();
    checkOutput("dValid1", 32'(dec_valid_out), 32'd0);
    checkOutput("dAddr1",  mem_addr_out, 32'h80020104);
    tick();
    checkOutput("dValid2", 32'(dec_valid_out), 32'd1);
    checkOutput("dPc",     dec_pc_out, 32'h80020100);
    checkOutput("dInsn",   dec_insn_out, 32'h7FFDFEFF);

    // Address wrap past the top of the 32-bit space
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFF8, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("eAddr0", mem_addr_out, 32'hFFFFFFF8);
    tick();
    checkOutput("eAddr1", mem_addr_out, 32'hFFFFFFFC);
    tick();
    checkOutput("eReq2",  32'(mem_req_out), 32'd1);
    checkOutput("eAddr2", mem_addr_out, 32'h00000000);
    checkOutput("ePc",    dec_pc_out, 32'hFFFFFFF8);
    checkOutput("eInsn",  dec_insn_out, 32'h00000007);

    // Reset pulse with a full queue
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (8) tick();
    checkOutput("fFull", 32'(count_out), 32'd4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("fRstReq",   32'(mem_req_out), 32'd0);
    checkOutput("fRstValid", 32'(dec_valid_out), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("fValid", 32'(dec_valid_out), 32'd0);
    checkOutput("fCount", 32'(count_out), 32'd0);
    checkOutput("fReq",   32'(mem_req_out), 32'd1);
    checkOutput("fAddr",  mem_addr_out, 32'h80020000);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("fPerfFetch0", perf_fetch_out, 32'd0);
    checkOutput("fPerfStall0", perf_stall_out, 32'd0);
`endif
    tick();
    tick();
    checkOutput("fPc",   dec_pc_out, 32'h80020000);
    checkOutput("fInsn", dec_insn_out, 32'h7FFDFFFF);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("fPerfFetch1", perf_fetch_out, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
